// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one UART transmitter among
//            N_REQ requesters. Latches the winner's byte, issues a one-cycle
//            active-low run strobe, then waits for tx_done (or a frame
//            timeout) before acknowledging and advancing the pointer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous reset, active low
//   clks_per_bit  in   baud divisor, used only for the timeout (0 = disabled)
//   req           in   level request per requester
//   req_data      in   flattened bytes, requester i at [i*data_width +: data_width]
//   ack           out  one-cycle completion pulse to the served requester
//   err           out  high with ack when the transfer ended by timeout
//   grant         out  one-hot owner of the transmitter, zero when idle
//   busy          out  high in any state other than IDLE
//   tx_data       out  byte to the UART
//   tx_en         out  active-low run strobe to the UART, idles high
//   tx_done       in   frame-complete pulse from the UART
// ============================================================================
module uart_tx_arbiter #(
   parameter int data_width = 8,
   parameter int N_REQ      = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [12:0]                 clks_per_bit,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*data_width-1:0] req_data,
   output logic [N_REQ-1:0]            ack,
   output logic                        err,
   output logic [N_REQ-1:0]            grant,
   output logic                        busy,
   output logic [data_width-1:0]       tx_data,
   output logic                        tx_en,
   input  logic                        tx_done
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_ACK   = 2'd3
   } state_t;

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   owner;
   logic [16:0]     cnt;

   logic [PW-1:0]   pick;
   logic            pick_valid;
   logic [PW:0]     idx;
   logic [16:0]     cnt_inc;
   logic [16:0]     limit;
   logic            timeout;

   logic [data_width-1:0] req_bytes [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign req_bytes[g] = req_data[g*data_width +: data_width];
   end

   // First set request bit searching upward from ptr, wrapping modulo N_REQ.
   always_comb begin
      pick       = '0;
      pick_valid = 1'b0;
      idx        = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = {1'b0, ptr} + (PW+1)'(i);
         if (idx >= (PW+1)'(N_REQ)) begin
            idx = idx - (PW+1)'(N_REQ);
         end
         if (!pick_valid && req[idx[PW-1:0]]) begin
            pick_valid = 1'b1;
            pick       = idx[PW-1:0];
         end
      end
   end

   // The counter value after this WAIT cycle equals the number of WAIT
   // cycles spent so far, so the timeout fires on WAIT cycle 16*clks_per_bit.
   assign cnt_inc = cnt + 17'd1;
   assign limit   = {clks_per_bit, 4'b0000};
   assign timeout = (clks_per_bit != 13'd0) && (cnt_inc == limit);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         ptr     <= '0;
         owner   <= '0;
         cnt     <= '0;
         ack     <= '0;
         err     <= 1'b0;
         grant   <= '0;
         busy    <= 1'b0;
         tx_data <= '0;
         tx_en   <= 1'b1;
      end else begin
         ack <= '0;
         err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_valid) begin
                  state   <= S_START;
                  owner   <= pick;
                  grant   <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                  tx_data <= req_bytes[pick];
                  tx_en   <= 1'b0;
                  cnt     <= '0;
                  busy    <= 1'b1;
               end
            end
            S_START: begin
               // tx_done is deliberately not looked at here.
               state <= S_WAIT;
               tx_en <= 1'b1;
            end
            S_WAIT: begin
               cnt <= cnt_inc;
               if (tx_done) begin
                  state <= S_ACK;
                  ack   <= grant;
               end else if (timeout) begin
                  state <= S_ACK;
                  ack   <= grant;
                  err   <= 1'b1;
               end
            end
            S_ACK: begin
               state <= S_IDLE;
               grant <= '0;
               busy  <= 1'b0;
               if (owner == PW'(N_REQ-1)) begin
                  ptr <= '0;
               end else begin
                  ptr <= owner + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter. A table of transactions
//            (request bits to raise, divisor, tx_done timing, expected winner,
//            byte, error flag and WAIT length) is applied in order, followed
//            by a hand-written mid-WAIT reset sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [12:0] clks_per_bit;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  ack;
   logic        err;
   logic [3:0]  grant;
   logic        busy;
   logic [7:0]  tx_data;
   logic        tx_en;
   logic        tx_done;

   int n_checks = 0;
   int n_errors = 0;
   int cur_vec  = -1;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .data_width (8),
      .N_REQ      (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .clks_per_bit (clks_per_bit),
      .req          (req),
      .req_data     (req_data),
      .ack          (ack),
      .err          (err),
      .grant        (grant),
      .busy         (busy),
      .tx_data      (tx_data),
      .tx_en        (tx_en),
      .tx_done      (tx_done)
   );

   typedef struct {
      logic [3:0]  req_set;
      logic [12:0] cpb;
      int          done_at;    // WAIT cycle in which tx_done is driven (-1 never)
      bit          dis;        // drive tx_done during START
      bit          drop;       // withdraw req one cycle after the grant
      logic [3:0]  exp_grant;
      logic [7:0]  exp_data;
      bit          exp_err;
      int          exp_waits;
   } vec_t;

   vec_t vecs [18];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s (vec %0d): got %0h expected %0h", nm, cur_vec, act, exp);
      end
   endtask

   task automatic serve(input vec_t v);
      int waits;
      bit seen;
      req          = req | v.req_set;
      clks_per_bit = v.cpb;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (tx_en == 1'b0) begin
            seen = 1'b1;
            break;
         end
      end
      chk("start_seen", 32'(seen), 32'd1);
      if (!seen) return;
      chk("grant", 32'(grant), 32'(v.exp_grant));
      chk("tx_data", 32'(tx_data), 32'(v.exp_data));
      chk("busy_start", 32'(busy), 32'd1);
      tx_done = v.dis;
      step();
      tx_done = 1'b0;
      chk("tx_en_one_cycle", 32'(tx_en), 32'd1);
      if (v.drop) req = req & ~v.exp_grant;
      waits = 1;
      seen  = 1'b0;
      while (waits <= 12000) begin
         tx_done = (waits == v.done_at);
         step();
         tx_done = 1'b0;
         if (ack != 4'b0000) begin
            seen = 1'b1;
            break;
         end
         chk("grant_held", 32'(grant), 32'(v.exp_grant));
         waits++;
      end
      chk("ack_seen", 32'(seen), 32'd1);
      chk("ack", 32'(ack), 32'(v.exp_grant));
      chk("err", 32'(err), 32'(v.exp_err));
      chk("wait_cycles", 32'(waits), 32'(v.exp_waits));
      chk("tx_data_held", 32'(tx_data), 32'(v.exp_data));
      req = req & ~ack;
      step();
      chk("ack_pulse", 32'(ack), 32'd0);
      chk("err_clear", 32'(err), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("grant_idle", 32'(grant), 32'd0);
   endtask

   task automatic chk_reset_vals();
      chk("rst_tx_en", 32'(tx_en), 32'd1);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
   endtask

   initial begin
      vec_t r;
      bit   seen;

      // Requester bytes: 0=5A, 1=A5, 2=C3, 3=0F
      req_data     = {8'h0F, 8'hC3, 8'hA5, 8'h5A};
      rst          = 1'b0;
      req          = 4'b0000;
      tx_done      = 1'b0;
      clks_per_bit = 13'd4;

      //            req_set  cpb     done   dis  drop  grant    data   err  waits
      vecs[0]  = '{4'b1111, 13'd4,  12,    0,   0,    4'b0001, 8'h5A, 0,   12};
      vecs[1]  = '{4'b0000, 13'd4,  12,    0,   0,    4'b0010, 8'hA5, 0,   12};
      vecs[2]  = '{4'b0000, 13'd4,  12,    0,   0,    4'b0100, 8'hC3, 0,   12};
      vecs[3]  = '{4'b0000, 13'd4,  12,    0,   0,    4'b1000, 8'h0F, 0,   12};
      vecs[4]  = '{4'b0010, 13'd4,  40,    0,   0,    4'b0010, 8'hA5, 0,   40};
      vecs[5]  = '{4'b1001, 13'd4,  12,    0,   0,    4'b1000, 8'h0F, 0,   12};
      vecs[6]  = '{4'b0000, 13'd4,  12,    0,   0,    4'b0001, 8'h5A, 0,   12};
      vecs[7]  = '{4'b1001, 13'd4,  12,    0,   0,    4'b1000, 8'h0F, 0,   12};
      vecs[8]  = '{4'b0000, 13'd4,  12,    0,   0,    4'b0001, 8'h5A, 0,   12};
      vecs[9]  = '{4'b1000, 13'd4,  12,    0,   0,    4'b1000, 8'h0F, 0,   12};
      vecs[10] = '{4'b1001, 13'd4,  12,    0,   0,    4'b0001, 8'h5A, 0,   12};
      vecs[11] = '{4'b0000, 13'd4,  12,    0,   0,    4'b1000, 8'h0F, 0,   12};
      vecs[12] = '{4'b0100, 13'd3,  -1,    0,   0,    4'b0100, 8'hC3, 1,   48};
      vecs[13] = '{4'b0010, 13'd3,  20,    0,   0,    4'b0010, 8'hA5, 0,   20};
      vecs[14] = '{4'b0001, 13'd3,  48,    0,   0,    4'b0001, 8'h5A, 0,   48};
      vecs[15] = '{4'b1000, 13'd4,  7,     1,   0,    4'b1000, 8'h0F, 0,   7};
      vecs[16] = '{4'b0100, 13'd0,  10000, 0,   0,    4'b0100, 8'hC3, 0,   10000};
      vecs[17] = '{4'b0001, 13'd4,  6,     0,   1,    4'b0001, 8'h5A, 0,   6};

      repeat (3) step();
      chk_reset_vals();
      rst = 1'b1;
      step();

      for (int i = 0; i < 18; i++) begin
         cur_vec = i;
         serve(vecs[i]);
      end

      // Reset in the middle of WAIT: pointer is 1 here, requester 2 in flight.
      cur_vec      = 100;
      clks_per_bit = 13'd4;
      req          = 4'b0100;
      seen         = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (tx_en == 1'b0) begin
            seen = 1'b1;
            break;
         end
      end
      chk("mid_start_seen", 32'(seen), 32'd1);
      chk("mid_grant", 32'(grant), 32'b0100);
      req = 4'b0000;
      step();
      step();
      chk("mid_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      chk_reset_vals();
      step();
      chk_reset_vals();
      rst = 1'b1;

      // Pointer restarts at 0: requester 0 wins over 3, then 3.
      cur_vec = 101;
      r = '{4'b1001, 13'd4, 5, 0, 0, 4'b0001, 8'h5A, 0, 5};
      serve(r);
      cur_vec = 102;
      r = '{4'b0000, 13'd4, 5, 0, 0, 4'b1000, 8'h0F, 0, 5};
      serve(r);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single UART transmitter among `N_REQ` on-chip requesters. It sits between the requesters and the transmit side of `uart_module`. It latches the winning requester's byte and issues the active-low run strobe on `tx_en`. It then waits for `tx_done`, or a frame timeout, before acknowledging the requester and moving the round-robin pointer.

## Interface
- `data_width`, 8, byte width; matches `uart_module`.
- `N_REQ`, 4, number of requesters (2..8).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clks_per_bit`  in  13  baud divisor, same value fed to `uart_module`; used only for the timeout.
- `req`  in  N_REQ  level request per requester; data must be stable while `req[i]` is high.
- `req_data`  in  N_REQ*data_width  flattened bytes; requester i occupies bits [i*data_width +: data_width].
- `ack`  out  N_REQ  one-cycle pulse to the served requester at completion.
- `err`  out  1  high together with `ack` when the transfer ended by timeout.
- `grant`  out  N_REQ  one-hot owner of the transmitter; all zero when idle.
- `busy`  out  1  high in any state other than IDLE.
- `tx_data`  out  data_width  byte to `uart_module.data_tx`.
- `tx_en`  out  1  run strobe to `uart_module.tx_en`; active low, idles high.
- `tx_done`  in  1  frame-complete pulse from `uart_module`.

## Operation
- FSM states: IDLE, START, WAIT, ACK.
- IDLE: if any `req` bit is high, pick the winner and go to START.
  - The winner is the first set bit searching upward from pointer `ptr` and wrapping modulo N_REQ.
  - Load `tx_data` with the winner's byte, set `grant` one-hot, and clear the timeout counter.
- START: `tx_en`=0 for exactly this one cycle, then go to WAIT. A `tx_done` in this cycle is ignored.
- WAIT: `tx_en`=1 and the counter increments each cycle.
  - `tx_done`=1 → ACK with `err`=0.
  - If `clks_per_bit`≠0 and the counter equals `clks_per_bit`×16 → ACK with `err`=1.
  - If both conditions hold in the same cycle, `tx_done` wins and `err`=0.
  - `clks_per_bit`=0 disables the timeout.
- ACK: `ack[winner]`=1 for this cycle only, `ptr` ← (winner+1) mod N_REQ, `grant` cleared on exit, go to IDLE.
- `tx_data` and `grant` stay constant from START through ACK. Requester data is captured only at the IDLE→START edge.
- `req` dropped after the grant does not abort the transfer; the frame still completes and `ack` still pulses.
- `req[i]` still high in the cycle after `ack[i]` counts as a new request. Requesters must drop `req` on seeing `ack`.
- Counter is 17 bits. The comparison is against the zero-extended {clks_per_bit, 4'b0}; no overflow is possible.
- Reset (any state, including mid-frame) forces IDLE with `ptr`=0, `tx_en`=1, `tx_data`=0, `grant`=0, `ack`=0, `err`=0, `busy`=0, counter=0.
- A frame already started in the UART is not cancelled by this block's reset. The system resets both blocks together.

## Timing
- All outputs are registered.
- `req` high at edge k while IDLE:
  - edge k+1: START, `tx_en`=0, `grant`, `busy` and `tx_data` valid;
  - edge k+2: WAIT, `tx_en`=1.
- `tx_done` sampled high at edge m in WAIT → `ack`/`err` high for the cycle after edge m+1.
- The next grant can start at the edge after ACK. Minimum spacing between `tx_en` low pulses is 4 cycles plus the UART frame time.
- Timeout fires at WAIT cycle count 16×`clks_per_bit`. This exceeds one 10-bit frame (10×`clks_per_bit`) with margin.

## Test plan
- Single request: `req`=4'b0010, byte 8'hA5, `clks_per_bit`=4.
  - `tx_en` low exactly one cycle, `tx_data`=A5, `grant`=0010.
  - Serial line carries A5 framed; after `tx_done`, `ack`=0010 for one cycle, `err`=0, `ptr`=2.
- Round-robin: all four `req` high continuously, each dropped on its `ack`.
  - Service order 0,1,2,3.
  - Re-raise `req[0]` and `req[3]` with `ptr`=0: order 0 then 3.
  - Repeat with `ptr`=1: order 3 then 0.
- Timeout: `tx_done` tied low, `clks_per_bit`=3.
  - `ack` plus `err`=1 after exactly 48 WAIT cycles; next request is served normally.
- Simultaneous events: `tx_done` and the timeout match in the same cycle → `err`=0. `tx_done` asserted during START → ignored, FSM stays in WAIT.
- Request withdrawn and reset:
  - Drop `req` one cycle after the grant → frame completes and `ack` still pulses.
  - Assert `rst`=0 mid-WAIT → all outputs at reset values immediately, `ptr`=0, new request served after release.
- `clks_per_bit`=0 with `tx_done` delayed 10000 cycles → no timeout, `ack` only after `tx_done`.
